toeplitz_acc: RTL

TOEPLITZ_ACC -- requirements
Module: toeplitz_acc

---
 rtl/toeplitz_acc.sv | 118 +++++++++++
 1 files changed

// File: rtl/toeplitz_acc.sv
// Toeplitz GF(2) accumulator: XORs streamed matrix rows into the result under control of coefficient bits, MSB first.
// Optional abort input is enabled by defining TOEPLITZ_ABORT_EN.
module toeplitz_acc #(
    parameter int unsigned OUT_W     = 3072,
    parameter int unsigned COEFF_W   = 32,
    parameter int unsigned NUM_WORDS = 128
) (
    input  logic               clk_in,
    input  logic               rst,
`ifdef TOEPLITZ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic [COEFF_W-1:0] coeff,
    input  logic               coeff_valid,
    output logic               coeff_ready,
    input  logic [OUT_W-1:0]   row_in,
    input  logic               row_valid,
    output logic               row_ready,
    output logic [OUT_W-1:0]   result,
    output logic               result_valid,
    output logic               busy
);

    localparam int unsigned BIT_W  = $clog2(COEFF_W + 1);
    localparam int unsigned WORD_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

    state_t             state;
    logic [COEFF_W-1:0] shift_word;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]  word_cnt;
    logic               abort_c;

`ifdef TOEPLITZ_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Single-process FSM; handshake flags are registered alongside the state
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift_word   <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            coeff_ready  <= 1'b0;
            row_ready    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        result      <= '0;
                        word_cnt    <= '0;
                        state       <= FETCH;
                        coeff_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    if (abort_c) begin
                        state       <= IDLE;
                        coeff_ready <= 1'b0;
                        busy        <= 1'b0;
                    end else if (coeff_valid && coeff_ready) begin
                        shift_word  <= coeff;
                        bit_cnt     <= '0;
                        state       <= ACC;
                        coeff_ready <= 1'b0;
                        row_ready   <= 1'b1;
                    end
                end
                ACC: begin
                    if (abort_c) begin
                        state     <= IDLE;
                        row_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (row_valid && row_ready) begin
                        if (shift_word[COEFF_W-1]) begin
                            result <= result ^ row_in;
                        end
                        shift_word <= shift_word << 1;
                        bit_cnt    <= bit_cnt + BIT_W'(1);
                        // Last bit of the current word: advance to next word or finish
                        if (bit_cnt == BIT_W'(COEFF_W - 1)) begin
                            word_cnt  <= word_cnt + WORD_W'(1);
                            row_ready <= 1'b0;
                            if (word_cnt == WORD_W'(NUM_WORDS - 1)) begin
                                state        <= DONE;
                                result_valid <= 1'b1;
                            end else begin
                                state       <= FETCH;
                                coeff_ready <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    coeff_ready <= 1'b0;
                    row_ready   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
